// File: rtl/weight_dbuf_ctrl_if.sv
// Bundle of weight-loader, SRAM write and compute-handshake signals for weight_dbuf_ctrl.
// slave is the controller side, master is the driver/observer side.
interface weight_dbuf_ctrl_if #(
    parameter int LEN_W  = 11,
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic              load_start_i;
    logic [LEN_W-1:0]  load_len_i;
    logic              load_ack_o;
    logic              ext_valid_i;
    logic [DATA_W-1:0] ext_data_i;
    logic              ext_ready_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_waddr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              comp_req_i;
    logic              comp_active_o;
    logic              comp_buf_o;
    logic              comp_done_i;
    logic [1:0]        buf_full_o;
    logic              load_busy_o;
    logic [15:0]       stall_cnt_o;

    modport slave (
        input  load_start_i, load_len_i, ext_valid_i, ext_data_i, comp_req_i, comp_done_i,
        output load_ack_o, ext_ready_o, mem_we_o, mem_waddr_o, mem_wdata_o,
               comp_active_o, comp_buf_o, buf_full_o, load_busy_o, stall_cnt_o
    );

    modport master (
        output load_start_i, load_len_i, ext_valid_i, ext_data_i, comp_req_i, comp_done_i,
        input  load_ack_o, ext_ready_o, mem_we_o, mem_waddr_o, mem_wdata_o,
               comp_active_o, comp_buf_o, buf_full_o, load_busy_o, stall_cnt_o
    );
endinterface

// File: rtl/weight_dbuf_ctrl.sv
// Ping-pong controller for the two 8 KiB halves of the weight memory: loads one half while compute uses the other.
// Optional compute-stall counter enabled by defining WBUF_STALL_CNT_EN.
//
// Loader FSM
//   state  | meaning
//   L_IDLE | waiting for load_start_i with buffer[wr_ptr] EMPTY
//   L_LOAD | accepting words into buffer[wr_ptr]
// Compute FSM
//   state    | meaning
//   C_IDLE   | waiting for comp_req_i with buffer[rd_ptr] FULL
//   C_ACTIVE | buffer[rd_ptr] granted to compute, waiting for comp_done_i
module weight_dbuf_ctrl #(
    parameter int TOTAL_WEIGHT_MEMORY_SIZE      = 16384,
    parameter int PER_BUFFER_WEIGHT_MEMORY_SIZE = 8192,
    parameter int BIT_WIDTH_EXTERNAL_PORT       = 32,
    parameter int WEIGHT_MEMORY_ADDR_SIZE       = 14,
    parameter int LEN_W                         = 11
) (
    input  logic                clk,
    input  logic                reset,
    weight_dbuf_ctrl_if.slave   bus
);
    localparam int NUM_BUFS = TOTAL_WEIGHT_MEMORY_SIZE / PER_BUFFER_WEIGHT_MEMORY_SIZE;
    localparam int BYTE_W   = $clog2(BIT_WIDTH_EXTERNAL_PORT / 8);
    localparam logic [LEN_W-1:0] LEN_ONE = 1;

    typedef enum logic [1:0] {B_EMPTY, B_FULL, B_IN_USE} buf_state_t;
    typedef enum logic {L_IDLE, L_LOAD} ld_state_t;
    typedef enum logic {C_IDLE, C_ACTIVE} cp_state_t;

    ld_state_t  ld_q, ld_d;
    cp_state_t  cp_q, cp_d;
    buf_state_t buf_q [NUM_BUFS];

    logic                                wr_ptr;
    logic                                rd_ptr;
    logic [LEN_W-1:0]                    len_q;
    logic [LEN_W-1:0]                    cnt;
    logic                                load_ack_q;
    logic                                mem_we_q;
    logic [WEIGHT_MEMORY_ADDR_SIZE-1:0]  mem_waddr_q;
    logic [BIT_WIDTH_EXTERNAL_PORT-1:0]  mem_wdata_q;
    logic                                comp_buf_q;
    logic [NUM_BUFS-1:0]                 full_vec;

    logic load_accept;
    logic wr_hs;
    logic last_word;
    logic grant;
    logic release_buf;

    always_ff @(posedge clk) begin
        if (reset) begin
            ld_q <= L_IDLE;
            cp_q <= C_IDLE;
        end else begin
            ld_q <= ld_d;
            cp_q <= cp_d;
        end
    end

    // len_q - 1 wraps to 2047 when len_q is 0, which gives the 2048-word load for free.
    always_comb begin
        ld_d        = ld_q;
        load_accept = 1'b0;
        wr_hs       = 1'b0;
        last_word   = 1'b0;
        case (ld_q)
            L_IDLE: begin
                if (bus.load_start_i && (buf_q[wr_ptr] == B_EMPTY)) begin
                    load_accept = 1'b1;
                    ld_d        = L_LOAD;
                end
            end
            L_LOAD: begin
                if (bus.ext_valid_i) begin
                    wr_hs = 1'b1;
                    if (cnt == (len_q - LEN_ONE)) begin
                        last_word = 1'b1;
                        ld_d      = L_IDLE;
                    end
                end
            end
            default: ld_d = L_IDLE;
        endcase
    end

    always_comb begin
        cp_d        = cp_q;
        grant       = 1'b0;
        release_buf = 1'b0;
        case (cp_q)
            C_IDLE: begin
                if (bus.comp_req_i && (buf_q[rd_ptr] == B_FULL)) begin
                    grant = 1'b1;
                    cp_d  = C_ACTIVE;
                end
            end
            C_ACTIVE: begin
                if (bus.comp_done_i) begin
                    release_buf = 1'b1;
                    cp_d        = C_IDLE;
                end
            end
            default: cp_d = C_IDLE;
        endcase
    end

    // Loader only ever touches an EMPTY buffer and compute only a FULL/IN_USE one, so they never collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < NUM_BUFS; b++) buf_q[b] <= B_EMPTY;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            len_q       <= '0;
            cnt         <= '0;
            load_ack_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
            comp_buf_q  <= 1'b0;
        end else begin
            load_ack_q <= load_accept;
            mem_we_q   <= wr_hs;
            if (load_accept) begin
                len_q <= bus.load_len_i;
                cnt   <= '0;
            end
            if (wr_hs) begin
                mem_waddr_q <= {wr_ptr, cnt, {BYTE_W{1'b0}}};
                mem_wdata_q <= bus.ext_data_i;
                cnt         <= cnt + LEN_ONE;
            end
            if (last_word) begin
                buf_q[wr_ptr] <= B_FULL;
                wr_ptr        <= ~wr_ptr;
            end
            if (grant) begin
                buf_q[rd_ptr] <= B_IN_USE;
                comp_buf_q    <= rd_ptr;
            end
            if (release_buf) begin
                buf_q[rd_ptr] <= B_EMPTY;
                rd_ptr        <= ~rd_ptr;
            end
        end
    end

    always_comb begin
        full_vec = '0;
        for (int b = 0; b < NUM_BUFS; b++) full_vec[b] = (buf_q[b] != B_EMPTY);
    end

    assign bus.load_ack_o    = load_ack_q;
    assign bus.ext_ready_o   = (ld_q == L_LOAD);
    assign bus.load_busy_o   = (ld_q == L_LOAD);
    assign bus.mem_we_o      = mem_we_q;
    assign bus.mem_waddr_o   = mem_waddr_q;
    assign bus.mem_wdata_o   = mem_wdata_q;
    assign bus.comp_active_o = (cp_q == C_ACTIVE);
    assign bus.comp_buf_o    = comp_buf_q;
    assign bus.buf_full_o    = full_vec;

`ifdef WBUF_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if (bus.comp_req_i && (cp_q != C_ACTIVE) && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign bus.stall_cnt_o = stall_q;
`else
    assign bus.stall_cnt_o = '0;
`endif
endmodule
